// File: rtl/key_event_pkg.sv
// Shared types for the key event classifier: FSM state encoding and the event pulse bundle.
package key_event_pkg;

    localparam int KEY_STATE_W = 3;

    typedef enum logic [KEY_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_LONG   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } key_state_t;

    typedef struct packed {
        logic press;
        logic rls;
        logic lng;
        logic rpt;
        logic dclick;
    } key_evt_t;

endpackage

// File: rtl/key_event_if.sv
// Key level in, classified event pulses and held level out; i_/o_ are from the classifier's side.
interface key_event_if;

    logic i_key_n;
    logic o_press;
    logic o_release;
    logic o_long_press;
    logic o_repeat;
    logic o_dclick;
    logic o_held;

    modport master (
        output i_key_n,
        input  o_press, o_release, o_long_press, o_repeat, o_dclick, o_held
    );

    modport slave (
        input  i_key_n,
        output o_press, o_release, o_long_press, o_repeat, o_dclick, o_held
    );

endinterface

// File: rtl/key_edge.sv
// Samples an active-low key level and flags press/release edges; edges valid 1 cycle after sampling.
// No backpressure: edge flags are combinational decodes of two history registers.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pe,
    output logic o_re
);

    logic r_key_q;
    logic r_key_d;

    // History resets to "released" so a key held through reset still yields one press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q <= 1'b1;
            r_key_d <= 1'b1;
        end else begin
            r_key_q <= i_key_n;
            r_key_d <= r_key_q;
        end
    end

    assign o_pe = r_key_d & ~r_key_q;
    assign o_re = ~r_key_d & r_key_q;

endmodule

// File: rtl/key_event.sv
// Classifies one debounced key into press/release/long/repeat/double-click pulses, 2 cycles after sampling.
// No backpressure: every event is a registered one-cycle pulse that downstream must take when it fires.
module key_event
    import key_event_pkg::*;
#(
    parameter int LONG_CNT   = 25_000_000,
    parameter int REPEAT_CNT = 5_000_000,
    parameter int DCLICK_CNT = 12_500_000,
    parameter int CNT_W      = 25
) (
    input  logic         clk,
    input  logic         rst,
    key_event_if.slave   bus
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);

    logic             w_pe;
    logic             w_re;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    key_evt_t         r_evt;
    key_evt_t         w_evt;
    logic             r_held;
    logic             w_held_nxt;

    key_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (bus.i_key_n),
        .o_pe    (w_pe),
        .o_re    (w_re)
    );

    // Edges are tested before terminal counts so a coincident edge always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_evt       = '0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pe) begin
                    w_state_nxt = ST_PRESS;
                    w_evt.press = 1'b1;
                end
            end
            ST_PRESS, ST_PRESS2: begin
                if (w_re) begin
                    w_evt.rls = 1'b1;
                    if (r_state == ST_PRESS) begin
                        w_state_nxt = ST_WAIT2;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_cnt == LONG_TC) begin
                    w_state_nxt = ST_LONG;
                    w_evt.lng   = 1'b1;
                end
            end
            ST_LONG: begin
                if (w_re) begin
                    w_state_nxt = ST_IDLE;
                    w_evt.rls   = 1'b1;
                end else if (r_cnt == REPEAT_TC) begin
                    w_evt.rpt = 1'b1;
                    w_cnt_nxt = '0;
                end
            end
            ST_WAIT2: begin
                if (w_pe) begin
                    w_state_nxt  = ST_PRESS2;
                    w_evt.press  = 1'b1;
                    w_evt.dclick = 1'b1;
                end else if (r_cnt == DCLICK_TC) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
        w_held_nxt = (w_state_nxt == ST_PRESS) || (w_state_nxt == ST_PRESS2) ||
                     (w_state_nxt == ST_LONG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_evt   <= '0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_evt   <= w_evt;
            r_held  <= w_held_nxt;
        end
    end

    assign bus.o_press      = r_evt.press;
    assign bus.o_release    = r_evt.rls;
    assign bus.o_long_press = r_evt.lng;
    assign bus.o_repeat     = r_evt.rpt;
    assign bus.o_dclick     = r_evt.dclick;
    assign bus.o_held       = r_held;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event with small interval counts; every cycle is also compared against a timestamp model.
module tb_key_event;

    localparam int LONG_CNT   = 8;
    localparam int REPEAT_CNT = 4;
    localparam int DCLICK_CNT = 6;

    // Observation vector bit positions: {press, release, long, repeat, dclick, held}
    localparam int P_PRESS = 5;
    localparam int P_REL   = 4;
    localparam int P_LONG  = 3;
    localparam int P_REP   = 2;
    localparam int P_DCL   = 1;
    localparam int P_HELD  = 0;

    typedef struct {
        logic       key_n;
        logic [5:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [5:0] obs;
    logic [5:0] logv [0:63];
    int         seg_t;

    // Reference model state: sampled key history plus timestamps of press, last tick and release.
    int         m_t;
    int         m_start;
    int         m_last;
    int         m_wstart;
    bit         m_q1;
    bit         m_q2;
    bit         m_held;
    bit         m_long;
    bit         m_win;
    bit         m_second;
    logic [5:0] m_exp;

    key_event_if kif ();

    key_event #(
        .LONG_CNT   (LONG_CNT),
        .REPEAT_CNT (REPEAT_CNT),
        .DCLICK_CNT (DCLICK_CNT),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic k);
        bit pe;
        bit re;
        m_exp = '0;
        m_t++;
        if (r) begin
            m_q1 = 1'b1; m_q2 = 1'b1;
            m_held = 1'b0; m_long = 1'b0; m_win = 1'b0; m_second = 1'b0;
        end else begin
            pe = m_q2 & ~m_q1;
            re = ~m_q2 & m_q1;
            if (m_held) begin
                if (re) begin
                    m_exp[P_REL] = 1'b1;
                    m_held = 1'b0;
                    if (!m_long && !m_second) begin
                        m_win = 1'b1;
                        m_wstart = m_t;
                    end
                    m_long = 1'b0;
                end else if (!m_long) begin
                    if (m_t - m_start == LONG_CNT) begin
                        m_exp[P_LONG] = 1'b1;
                        m_long = 1'b1;
                        m_last = m_t;
                    end
                end else if (m_t - m_last == REPEAT_CNT) begin
                    m_exp[P_REP] = 1'b1;
                    m_last = m_t;
                end
            end else if (m_win) begin
                if (pe) begin
                    m_exp[P_PRESS] = 1'b1;
                    m_exp[P_DCL] = 1'b1;
                    m_held = 1'b1; m_second = 1'b1; m_win = 1'b0;
                    m_start = m_t;
                end else if (m_t - m_wstart == DCLICK_CNT) begin
                    m_win = 1'b0;
                end
            end else if (pe) begin
                m_exp[P_PRESS] = 1'b1;
                m_held = 1'b1; m_second = 1'b0;
                m_start = m_t;
            end
            m_q2 = m_q1;
            m_q1 = k;
        end
        m_exp[P_HELD] = m_held;
    endtask

    task automatic tick(input logic r, input logic k);
        rst = r;
        kif.i_key_n = k;
        @(posedge clk);
        model_edge(r, k);
        #1;
        obs = {kif.o_press, kif.o_release, kif.o_long_press, kif.o_repeat, kif.o_dclick, kif.o_held};
        chk("model", obs, m_exp);
        seg_t++;
        if (seg_t < 64) logv[seg_t] = obs;
    endtask

    task automatic lo(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic hi(input int n);
        repeat (n) tick(1'b0, 1'b1);
    endtask

    task automatic seg_begin();
        seg_t = 0;
        for (int i = 0; i < 64; i++) logv[i] = '0;
    endtask

    function automatic int nbits(input int pos, input int a, input int b);
        int s;
        s = 0;
        for (int i = a; i <= b; i++) s += int'(logv[i][pos]);
        return s;
    endfunction

    vec_t vtab [15];

    initial begin
        logic k;
        int   len;

        checks = 0;
        errors = 0;
        m_t = 0;
        seg_t = 0;
        rst = 1'b1;
        kif.i_key_n = 1'b1;

        // Short press from reset: low 5, high 10
        vtab[0]  = '{1'b0, 6'b000000};
        vtab[1]  = '{1'b0, 6'b100001};
        vtab[2]  = '{1'b0, 6'b000001};
        vtab[3]  = '{1'b0, 6'b000001};
        vtab[4]  = '{1'b0, 6'b000001};
        vtab[5]  = '{1'b1, 6'b000001};
        vtab[6]  = '{1'b1, 6'b010000};
        for (int i = 7; i < 15; i++) vtab[i] = '{1'b1, 6'b000000};

        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("reset_outputs", obs, 6'b000000);

        seg_begin();
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, vtab[i].key_n);
            chk($sformatf("short_press_row%0d", i), obs, vtab[i].exp);
        end
        hi(10);

        // Long press with repeats, then a quick press that must not be a double-click
        seg_begin();
        lo(22); hi(3); lo(3); hi(12);
        chk("long_press_at_t", logv[2], 6'b100001);
        chk("long_at_t8", logv[10], 6'b001001);
        chk("repeat_t12", logv[14], 6'b000101);
        chk("repeat_t16", logv[18], 6'b000101);
        chk("repeat_t20", logv[22], 6'b000101);
        chk_i("repeat_count", nbits(P_REP, 1, 40), 3);
        chk("long_held_before_rel", logv[23], 6'b000001);
        chk("long_release", logv[24], 6'b010000);
        chk("after_long_no_dclick", logv[27], 6'b100001);

        // Double-click then a third press
        seg_begin();
        lo(3); hi(3); lo(3); hi(2); lo(3); hi(12);
        chk("dc_first", logv[2], 6'b100001);
        chk("dc_second", logv[8], 6'b100011);
        chk("dc_third", logv[13], 6'b100001);
        chk_i("dc_count", nbits(P_DCL, 1, 26), 1);

        // Window expiry
        seg_begin();
        lo(3); hi(8); lo(3); hi(12);
        chk("expiry_second", logv[13], 6'b100001);
        chk_i("expiry_press_count", nbits(P_PRESS, 1, 26), 2);
        chk_i("expiry_dclick_count", nbits(P_DCL, 1, 26), 0);

        // Release coincides with long-press terminal count
        seg_begin();
        lo(8); hi(12);
        chk("rel_at_long_tc", logv[10], 6'b010000);
        chk_i("rel_at_long_tc_nolong", nbits(P_LONG, 1, 20), 0);

        // Release coincides with repeat terminal count
        seg_begin();
        lo(16); hi(12);
        chk("rep_before_tc", logv[14], 6'b000101);
        chk("rel_at_rep_tc", logv[18], 6'b010000);
        chk_i("rel_at_rep_tc_count", nbits(P_REP, 1, 28), 1);

        // Second press coincides with the double-click timeout
        seg_begin();
        lo(3); hi(6); lo(3); hi(12);
        chk("pe_tmo_release", logv[5], 6'b010000);
        chk("pe_beats_timeout", logv[11], 6'b100011);

        // Reset in the middle of a long press
        seg_begin();
        lo(12); tick(1'b1, 1'b0); hi(12);
        chk("mid_long_held", logv[12], 6'b000001);
        chk("mid_long_rst", logv[13], 6'b000000);
        chk_i("mid_long_no_release", nbits(P_REL, 13, 25), 0);

        // Key held low through reset
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        chk("rst_low_outputs", obs, 6'b000000);
        seg_begin();
        lo(6); hi(12);
        chk("rst_low_first", logv[1], 6'b000000);
        chk("rst_low_press", logv[2], 6'b100001);
        chk_i("rst_low_press_count", nbits(P_PRESS, 1, 6), 1);

        // Random key runs with occasional resets
        for (int n = 0; n < 200; n++) begin
            k = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            if ($urandom_range(0, 40) == 0) tick(1'b1, k);
            repeat (len) tick(1'b0, k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
